// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS-lite MEM stage with an internal word-addressed data memory,
// the MEM/WB pipeline register, sticky halt/misalign flags and saturating load/store counters.
module mem_access_stage #(
   parameter int DATA      = 32,
   parameter int REG_WIDTH = 5,
   parameter int DEPTH     = 1024,
   parameter int COUNT_W   = 32,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 init_en,
   input  logic [AW-1:0]        init_addr,
   input  logic [DATA-1:0]      init_data,
   input  logic                 ex_valid,
   input  logic [DATA-1:0]      ex_alu_result,
   input  logic [DATA-1:0]      ex_store_data,
   input  logic [REG_WIDTH-1:0] ex_dest_reg,
   input  logic                 ex_mem_read,
   input  logic                 ex_mem_write,
   input  logic                 ex_reg_write,
   input  logic                 ex_wb_mux,
   input  logic                 ex_halt,
   output logic                 mem_valid,
   output logic [REG_WIDTH-1:0] memory_read,
   output logic [DATA-1:0]      write_back_data,
   output logic [DATA-1:0]      memory_data_o,
   output logic                 mem_reg_write,
   output logic                 mem_wb_mux,
   output logic                 halt_detected,
   output logic                 misalign_error,
   output logic [COUNT_W-1:0]   load_count,
   output logic [COUNT_W-1:0]   store_count
);
   logic [DATA-1:0]      mem_q [DEPTH];
   logic [AW-1:0]        idx;
   logic                 accept, mem_op, unaligned, mis, is_ld, is_st, st_ok;
   logic                 valid_q, valid_d, regw_q, regw_d, wbm_q, wbm_d;
   logic                 halt_q, halt_d, mis_q, mis_d;
   logic [REG_WIDTH-1:0] dest_q, dest_d;
   logic [DATA-1:0]      wbd_q, wbd_d, md_q, md_d;
   logic [COUNT_W-1:0]   lc_q, lc_d, sc_q, sc_d;

   assign idx       = ex_alu_result[AW+1:2];
   assign accept    = ex_valid & ~halt_q & reset_n;
   assign mem_op    = ex_mem_read | ex_mem_write;
   assign unaligned = |ex_alu_result[1:0];
   assign mis       = accept & mem_op & unaligned;
   // Read+write together behaves as a store.
   assign is_ld     = accept & ex_mem_read & ~ex_mem_write & ~unaligned;
   assign is_st     = accept & ex_mem_write & ~unaligned;
   assign st_ok     = is_st & ~init_en;

   assign valid_d = accept;
   assign dest_d  = accept ? ex_dest_reg : '0;
   assign wbd_d   = accept ? ex_alu_result : '0;
   assign wbm_d   = accept & ex_wb_mux;
   assign regw_d  = accept & ex_reg_write & ~ex_halt & ~mis;
   assign md_d    = is_ld ? mem_q[idx] : '0;
   assign halt_d  = halt_q | (accept & ex_halt);
   assign mis_d   = mis_q | mis;
   assign lc_d    = lc_q + COUNT_W'(is_ld && lc_q != '1);
   assign sc_d    = sc_q + COUNT_W'(st_ok && sc_q != '1);

   // Memory has no reset so its image survives reset_n; writes are still blocked while reset_n is low.
   always_ff @(posedge clock)
      if (init_en && reset_n) mem_q[init_addr] <= init_data;
      else if (st_ok) mem_q[idx] <= ex_store_data;

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         valid_q <= 1'b0;
         dest_q  <= '0;
         wbd_q   <= '0;
         md_q    <= '0;
         regw_q  <= 1'b0;
         wbm_q   <= 1'b0;
         halt_q  <= 1'b0;
         mis_q   <= 1'b0;
         lc_q    <= '0;
         sc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         dest_q  <= dest_d;
         wbd_q   <= wbd_d;
         md_q    <= md_d;
         regw_q  <= regw_d;
         wbm_q   <= wbm_d;
         halt_q  <= halt_d;
         mis_q   <= mis_d;
         lc_q    <= lc_d;
         sc_q    <= sc_d;
      end

   assign mem_valid       = valid_q;
   assign memory_read     = dest_q;
   assign write_back_data = wbd_q;
   assign memory_data_o   = md_q;
   assign mem_reg_write   = regw_q;
   assign mem_wb_mux      = wbm_q;
   assign halt_detected   = halt_q;
   assign misalign_error  = mis_q;
   assign load_count      = lc_q;
   assign store_count     = sc_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed scenarios plus randomized bundles checked against a
// behavioural array/counter model of the MEM stage (counters narrowed to 4 bits to reach saturation).
module tb_mem_access_stage;
   logic        clock = 1'b0, reset_n = 1'b0, init_en = 1'b0;
   logic [9:0]  init_addr = '0;
   logic [31:0] init_data = '0, ex_alu_result = '0, ex_store_data = '0;
   logic [4:0]  ex_dest_reg = '0;
   logic        ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
   logic        ex_reg_write = 1'b0, ex_wb_mux = 1'b0, ex_halt = 1'b0;
   logic        mem_valid, mem_reg_write, mem_wb_mux, halt_detected, misalign_error;
   logic [4:0]  memory_read;
   logic [31:0] write_back_data, memory_data_o;
   logic [3:0]  load_count, store_count;
   int          checks = 0, errors = 0;

   logic [31:0] ref_mem [1024];
   logic        e_valid, e_rw, e_wbm, e_halt, e_mis;
   logic [4:0]  e_dest;
   logic [31:0] e_wbd, e_md;
   int          e_lc, e_sc;

   mem_access_stage #(.COUNT_W(4)) dut (
      .clock(clock), .reset_n(reset_n), .init_en(init_en), .init_addr(init_addr),
      .init_data(init_data), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
      .ex_store_data(ex_store_data), .ex_dest_reg(ex_dest_reg), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_wb_mux(ex_wb_mux),
      .ex_halt(ex_halt), .mem_valid(mem_valid), .memory_read(memory_read),
      .write_back_data(write_back_data), .memory_data_o(memory_data_o),
      .mem_reg_write(mem_reg_write), .mem_wb_mux(mem_wb_mux), .halt_detected(halt_detected),
      .misalign_error(misalign_error), .load_count(load_count), .store_count(store_count)
   );

   always #5 clock = ~clock;

   task automatic model_reset();
      e_valid = 0; e_rw = 0; e_wbm = 0; e_halt = 0; e_mis = 0;
      e_dest = 0; e_wbd = 0; e_md = 0; e_lc = 0; e_sc = 0;
   endtask

   // Reference: apply the current bundle to the model, then advance one clock.
   task automatic step();
      bit acc, al, ld, st, ms;
      int wi;
      if (!reset_n) model_reset();
      else begin
         acc = ex_valid && !e_halt;
         al = (ex_alu_result % 4) == 0;
         wi = int'((ex_alu_result / 4) % 1024);
         ld = acc && ex_mem_read && !ex_mem_write && al;
         st = acc && ex_mem_write && al;
         ms = acc && (ex_mem_read || ex_mem_write) && !al;
         e_valid = acc;
         e_dest = acc ? ex_dest_reg : 5'd0;
         e_wbd = acc ? ex_alu_result : 32'd0;
         e_wbm = acc && ex_wb_mux;
         e_rw = acc && ex_reg_write && !ex_halt && !ms;
         e_md = ld ? ref_mem[wi] : 32'd0;
         if (ms) e_mis = 1;
         if (acc && ex_halt) e_halt = 1;
         if (ld && e_lc < 15) e_lc++;
         if (init_en) ref_mem[init_addr] = init_data;
         else if (st) begin
            ref_mem[wi] = ex_store_data;
            if (e_sc < 15) e_sc++;
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [4:0] d, input logic r, input logic w, input logic rw,
                        input logic wbm, input logic h);
      ex_valid = v; ex_alu_result = alu; ex_store_data = sd; ex_dest_reg = d;
      ex_mem_read = r; ex_mem_write = w; ex_reg_write = rw; ex_wb_mux = wbm; ex_halt = h;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      init_en = 0;
   endtask

   task automatic init_word(input int a, input logic [31:0] d);
      init_en = 1; init_addr = 10'(a); init_data = d;
      step();
      init_en = 0;
   endtask

   task automatic test_reset();
      reset_n = 0; idle();
      step(); step();
      checks++; if (mem_valid !== 0 || mem_reg_write !== 0 || memory_data_o !== 0) begin errors++;
         $display("FAIL reset_out valid=%b rw=%b data=%h required 0", mem_valid, mem_reg_write, memory_data_o); end
      checks++; if (halt_detected !== 0 || misalign_error !== 0 || load_count !== 0 || store_count !== 0) begin errors++;
         $display("FAIL reset_flags halt=%b mis=%b lc=%0d sc=%0d required 0", halt_detected, misalign_error, load_count, store_count); end
      reset_n = 1;
      for (int i = 0; i < 16; i++) init_word(i, 32'h100 + i);
   endtask

   task automatic test_load();
      init_word(0, 32'h11); init_word(1, 32'h22); init_word(2, 32'h33); init_word(3, 32'h44);
      drive(1, 32'h8, 0, 5, 1, 0, 1, 0, 0); step(); idle();
      checks++; if (memory_data_o !== 32'h33) begin errors++; $display("FAIL lw_data got %h required 33", memory_data_o); end
      checks++; if (memory_read !== 5 || mem_reg_write !== 1 || mem_valid !== 1) begin errors++;
         $display("FAIL lw_ctrl dest=%0d rw=%b valid=%b required 5 1 1", memory_read, mem_reg_write, mem_valid); end
      checks++; if (load_count !== 1) begin errors++; $display("FAIL lw_count got %0d required 1", load_count); end
   endtask

   task automatic test_store_load();
      drive(1, 32'h10, 32'hDEADBEEF, 0, 0, 1, 0, 0, 0); step();
      checks++; if (store_count !== 1 || memory_data_o !== 0) begin errors++;
         $display("FAIL sw_count sc=%0d data=%h required 1 0", store_count, memory_data_o); end
      drive(1, 32'h10, 0, 7, 1, 0, 1, 0, 0); step(); idle();
      checks++; if (memory_data_o !== 32'hDEADBEEF || load_count !== 2) begin errors++;
         $display("FAIL sw_then_lw data=%h lc=%0d required deadbeef 2", memory_data_o, load_count); end
   endtask

   task automatic test_misalign();
      drive(1, 32'h6, 0, 4, 1, 0, 1, 0, 0); step();
      checks++; if (misalign_error !== 1 || mem_reg_write !== 0 || memory_data_o !== 0 || mem_valid !== 1) begin errors++;
         $display("FAIL misalign mis=%b rw=%b data=%h valid=%b required 1 0 0 1", misalign_error, mem_reg_write, memory_data_o, mem_valid); end
      checks++; if (load_count !== 2) begin errors++; $display("FAIL misalign_count got %0d required 2", load_count); end
      drive(1, 32'h4, 0, 4, 1, 0, 1, 0, 0); step(); idle();
      checks++; if (memory_data_o !== 32'h22 || mem_reg_write !== 1 || load_count !== 3 || misalign_error !== 1) begin errors++;
         $display("FAIL after_misalign data=%h rw=%b lc=%0d mis=%b required 22 1 3 1", memory_data_o, mem_reg_write, load_count, misalign_error); end
   endtask

   task automatic test_init_priority();
      init_en = 1; init_addr = 10'd12; init_data = 32'h1234;
      drive(1, 32'h30, 32'h9999, 0, 0, 1, 0, 0, 0); step(); idle();
      checks++; if (store_count !== 1) begin errors++; $display("FAIL init_prio_count got %0d required 1", store_count); end
      drive(1, 32'h30, 0, 1, 1, 0, 1, 0, 0); step(); idle();
      checks++; if (memory_data_o !== 32'h1234) begin errors++; $display("FAIL init_prio_data got %h required 1234", memory_data_o); end
   endtask

   task automatic test_saturation();
      drive(1, 32'h0, 0, 1, 1, 0, 1, 0, 0);
      repeat (20) step();
      idle();
      checks++; if (load_count !== 4'hF) begin errors++; $display("FAIL load_saturate got %0d required 15", load_count); end
   endtask

   task automatic test_reset_alias();
      drive(1, 32'h20, 0, 2, 1, 0, 1, 0, 0); step();
      drive(1, 32'h20, 32'h5, 0, 0, 1, 0, 0, 0);
      #2 reset_n = 0;
      #1;
      model_reset();
      checks++; if (mem_valid !== 0 || memory_data_o !== 0 || write_back_data !== 0 || memory_read !== 0) begin errors++;
         $display("FAIL async_reset valid=%b data=%h wbd=%h dest=%0d required 0", mem_valid, memory_data_o, write_back_data, memory_read); end
      checks++; if (load_count !== 0 || misalign_error !== 0 || store_count !== 0) begin errors++;
         $display("FAIL async_reset_flags lc=%0d mis=%b sc=%0d required 0", load_count, misalign_error, store_count); end
      step();
      reset_n = 1;
      drive(1, 32'h1020, 0, 2, 1, 0, 1, 0, 0); step(); idle();
      checks++; if (memory_data_o !== 32'h108 || load_count !== 1 || store_count !== 0) begin errors++;
         $display("FAIL alias_after_reset data=%h lc=%0d sc=%0d required 108 1 0", memory_data_o, load_count, store_count); end
   endtask

   task automatic test_halt();
      drive(1, 32'h7, 0, 3, 0, 0, 1, 1, 0); step();
      checks++; if (write_back_data !== 7 || mem_wb_mux !== 1 || mem_reg_write !== 1 || memory_read !== 3 || memory_data_o !== 0) begin errors++;
         $display("FAIL alu_op wbd=%h wbm=%b rw=%b dest=%0d data=%h required 7 1 1 3 0", write_back_data, mem_wb_mux, mem_reg_write, memory_read, memory_data_o); end
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1); step();
      checks++; if (halt_detected !== 1 || mem_valid !== 1 || mem_reg_write !== 0) begin errors++;
         $display("FAIL halt halt=%b valid=%b rw=%b required 1 1 0", halt_detected, mem_valid, mem_reg_write); end
      drive(1, 32'h0, 32'hBAD, 0, 0, 1, 0, 0, 0); step(); idle();
      checks++; if (mem_valid !== 0 || store_count !== 0 || halt_detected !== 1) begin errors++;
         $display("FAIL post_halt valid=%b sc=%0d halt=%b required 0 0 1", mem_valid, store_count, halt_detected); end
      init_word(1, 32'h77);
      reset_n = 0; step(); reset_n = 1;
      checks++; if (halt_detected !== 0) begin errors++; $display("FAIL halt_clear got %b required 0", halt_detected); end
      drive(1, 32'h0, 0, 1, 1, 0, 1, 0, 0); step();
      checks++; if (memory_data_o !== 32'h11) begin errors++; $display("FAIL halt_no_store got %h required 11", memory_data_o); end
      drive(1, 32'h4, 0, 1, 1, 0, 1, 0, 0); step(); idle();
      checks++; if (memory_data_o !== 32'h77) begin errors++; $display("FAIL init_in_halt got %h required 77", memory_data_o); end
   endtask

   task automatic test_random();
      int op;
      logic [31:0] alu;
      for (int n = 0; n < 400; n++) begin
         reset_n = !(e_halt && $urandom_range(0, 5) == 0);
         op = $urandom_range(0, 3);
         alu = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 15) << 2) |
               (($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0);
         drive($urandom_range(0, 7) != 0, alu, $urandom, 5'($urandom), op[0], op[1],
               1'($urandom), 1'($urandom), $urandom_range(0, 40) == 0);
         init_en = $urandom_range(0, 9) == 0;
         init_addr = 10'($urandom_range(0, 15));
         init_data = $urandom;
         step();
         checks++; if (mem_valid !== e_valid) begin errors++; $display("FAIL rnd_valid n=%0d got %b required %b", n, mem_valid, e_valid); end
         checks++; if (memory_read !== e_dest) begin errors++; $display("FAIL rnd_dest n=%0d got %0d required %0d", n, memory_read, e_dest); end
         checks++; if (write_back_data !== e_wbd) begin errors++; $display("FAIL rnd_wbd n=%0d got %h required %h", n, write_back_data, e_wbd); end
         checks++; if (memory_data_o !== e_md) begin errors++; $display("FAIL rnd_data n=%0d got %h required %h", n, memory_data_o, e_md); end
         checks++; if (mem_reg_write !== e_rw) begin errors++; $display("FAIL rnd_rw n=%0d got %b required %b", n, mem_reg_write, e_rw); end
         checks++; if (mem_wb_mux !== e_wbm) begin errors++; $display("FAIL rnd_wbm n=%0d got %b required %b", n, mem_wb_mux, e_wbm); end
         checks++; if (halt_detected !== e_halt) begin errors++; $display("FAIL rnd_halt n=%0d got %b required %b", n, halt_detected, e_halt); end
         checks++; if (misalign_error !== e_mis) begin errors++; $display("FAIL rnd_mis n=%0d got %b required %b", n, misalign_error, e_mis); end
         checks++; if (int'(load_count) !== e_lc) begin errors++; $display("FAIL rnd_lc n=%0d got %0d required %0d", n, load_count, e_lc); end
         checks++; if (int'(store_count) !== e_sc) begin errors++; $display("FAIL rnd_sc n=%0d got %0d required %0d", n, store_count, e_sc); end
      end
      reset_n = 1; idle();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_load();
      test_store_load();
      test_misalign();
      test_init_priority();
      test_saturation();
      test_reset_alias();
      test_halt();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS-lite pipeline.
- Consumes the EX/MEM bundle and performs data-memory loads and stores against an internal word array.
- Registers the MEM/WB bundle that the write-back stage consumes: dest reg, ALU result, load data, wbMux, regWrite and halt.
- Also holds the run-time load/store counters and a misalignment flag for the simulator summary.

Parameters:
- DATA, 32, data/address width in bits.
- REG_WIDTH, 5, register-index width.
- DEPTH, 1024, data-memory size in 32-bit words; power of two.
- COUNT_W, 32, width of the load and store counters.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- init_en  in  1  memory-image load strobe (pre-run).
- init_addr  in  log2(DEPTH)  word index for init write.
- init_data  in  DATA  word for init write.
- ex_valid  in  1  EX/MEM bundle holds a real instruction.
- ex_alu_result  in  DATA  ALU result / effective byte address.
- ex_store_data  in  DATA  rt value for SW.
- ex_dest_reg  in  REG_WIDTH  destination register.
- ex_mem_read  in  1  LW.
- ex_mem_write  in  1  SW.
- ex_reg_write  in  1  instruction writes the register file.
- ex_wb_mux  in  1  1 = write back ALU result, 0 = write back load data.
- ex_halt  in  1  HALT instruction.
- mem_valid  out  1  MEM/WB bundle valid.
- memory_read  out  REG_WIDTH  registered destination register.
- write_back_data  out  DATA  registered ALU result.
- memory_data_o  out  DATA  registered load data.
- mem_reg_write  out  1  registered regWrite.
- mem_wb_mux  out  1  registered wbMux.
- halt_detected  out  1  sticky halt, to write-back.
- misalign_error  out  1  sticky, addr[1:0] != 0 on LW/SW.
- load_count  out  COUNT_W  retired aligned LWs.
- store_count  out  COUNT_W  retired aligned SWs.

Behaviour:
- Reset: when reset_n = 0, all outputs and counters clear to 0 immediately. Memory contents are retained, not cleared.
- Memory writes are gated by reset_n, so a store coinciding with reset assertion is lost.
- Word index is ex_alu_result[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Accept condition: accept = ex_valid & !halt_detected & reset_n.
- Latency is 1 cycle. Bundle presented in cycle N appears on MEM/WB outputs after edge N and stays until the next edge.
- LW (accept & ex_mem_read & aligned): memory_data_o <= mem[index], read combinationally in cycle N; load_count increments.
- SW (accept & ex_mem_write & aligned): mem[index] <= ex_store_data at edge N; store_count increments; memory_data_o <= 0.
- Store followed by load to the same word in the next cycle: the load returns the new data, with no bypass needed.
- Non-memory instruction: memory_data_o <= 0.
- Misaligned LW/SW: no memory write, no count, memory_data_o <= 0, mem_reg_write <= 0, misalign_error set (sticky until reset). mem_valid still = 1.
- A bundle with both ex_mem_read and ex_mem_write set is treated as SW.
- Not accepted: mem_valid <= 0, mem_reg_write <= 0, no memory or counter effect. Other MEM/WB fields load 0.
- Halt: accept & ex_halt sets halt_detected at edge N, sticky until reset. The halt bundle itself passes with mem_valid = 1 and mem_reg_write forced 0. Every later bundle is ignored.
- init_en has priority over a same-cycle pipeline store: mem[init_addr] <= init_data, and the pipeline store is dropped and not counted. init_en works regardless of halt.
- Counters saturate at all-ones and never wrap.
- States: RUN and HALTED, with HALTED encoded as halt_detected = 1. Only reset_n leaves HALTED.

Test Plan:
- init words 0..3 = 0x11,0x22,0x33,0x44; LW addr 0x8 dest 5 wbMux 0 → next cycle memory_data_o = 0x33, memory_read = 5, mem_reg_write = 1, load_count = 1.
- SW 0xDEADBEEF to 0x10, then LW 0x10 next cycle → memory_data_o = 0xDEADBEEF, store_count = 1, load_count = 1.
- LW addr 0x6 → misalign_error = 1, mem_reg_write = 0, memory_data_o = 0, load_count unchanged; a following aligned LW still works.
- ADD result 0x7 dest 3 wbMux 1 then HALT then SW to 0x0 → write_back_data = 7, halt_detected = 1 one cycle after HALT, mem[0] unchanged, store_count = 0.
- SW 0x5 to 0x20 with reset_n pulsed low mid-cycle → all outputs 0 at once, mem[8] keeps its prior value; address 0x1020 with DEPTH = 1024 aliases to word 8.
- init_en and SW to the same word in one cycle → init_data stored, store_count unchanged.
